div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk and rst; polarity and synchronicity are fixed.
REQ-002 The ports SHALL be, in this order:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start_i  in  1  EX requests a divide; held high until ready_o
- signed_i  in  1  1 = DIV/REM, 0 = DIVU/REMU
- rem_i  in  1  1 = return remainder, 0 = return quotient
- op1_i  in  32  dividend (rs1)
- op2_i  in  32  divisor (rs2)
- annul_i  in  1  pipeline flush; abort current operation
- result_o  out  32  quotient or remainder
- ready_o  out  1  result_o valid, one-cycle pulse
- stallreq_o  out  1  EX must hold the instruction

Function
REQ-003 The block SHALL implement an FSM with states IDLE, CALC and DONE.
REQ-004 IDLE with start_i=1 and annul_i=0 SHALL:
- latch op1_i, op2_i, signed_i and rem_i
- go to DONE if op2_i==0, else to CALC with the iteration counter at 0.
REQ-005 CALC SHALL perform one radix-2 restoring step per cycle on the absolute values (signed_i=1) or raw values (signed_i=0), for exactly 32 cycles, then go to DONE.
REQ-006 DONE SHALL assert ready_o for exactly one cycle with result_o final, then return to IDLE.
REQ-007 Latency SHALL be: start accepted in cycle N -> ready_o in cycle N+33; divide-by-zero -> ready_o in cycle N+1.
REQ-008 Input changes during CALC or DONE SHALL be ignored.
REQ-009 start_i in DONE SHALL NOT begin a new operation; a start_i still high in the following IDLE cycle SHALL be treated as a new request.
REQ-010 stallreq_o SHALL be 1 when (IDLE and start_i and not annul_i) or CALC, and SHALL be 0 in DONE and otherwise.
REQ-011 Sign fix-up for signed_i=1:
- quotient negated when the operand signs differ
- remainder takes the sign of the dividend.
REQ-012 Divide-by-zero SHALL return quotient 0xFFFFFFFF and remainder equal to the dividend, regardless of signed_i.
REQ-013 Signed overflow 0x80000000 / 0xFFFFFFFF SHALL return quotient 0x80000000 and remainder 0.
REQ-014 annul_i=1 in any state SHALL force IDLE on the next edge, suppress ready_o in that cycle and deassert stallreq_o combinationally.
REQ-015 result_o SHALL hold its last value except when updated on entry to DONE.

Reset
REQ-016 rst SHALL drive the following on the next rising edge, overriding all other inputs:
- state IDLE
- counter 0
- internal registers 0
- result_o 0x00000000
- ready_o 0
- stallreq_o 0, unless start_i in IDLE after reset.
REQ-017 rst asserted mid-CALC SHALL discard the operation with no ready_o pulse.

Structure
REQ-018 The FSM state encoding, the iteration count constant (32) and the divide-by-zero quotient constant SHALL live in the shared def package with the existing ALUOP definitions.
REQ-019 Divide ALUOP bits (DIV, DIVU, REM, REMU) SHALL be added to the shared package; EX decodes them into start_i, signed_i and rem_i.
REQ-020 The block SHALL be a single module with no sub-module; the 33-bit partial-remainder subtractor is inline.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- DIVU 100/7, start at cycle 0 -> ready_o at cycle 33 with result 14; REMU repeat -> 2; stallreq_o 1 for cycles 0-32.
- DIV 0xFFFFFFF9 / 2 (-7/2) -> 0xFFFFFFFD; REM -> 0xFFFFFFFF.
- DIV 5/0 -> ready_o at cycle 1 with 0xFFFFFFFF; REM -> 5; DIVU 0xFFFFFFFF/0 -> 0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
- annul_i at CALC cycle 10 -> IDLE next cycle, no ready_o, stallreq_o 0; new DIVU 9/3 -> 3 after 33 cycles.
- rst at CALC cycle 20 -> all outputs 0, no ready_o; op1_i/op2_i toggled during CALC -> result unchanged.

Source files
------------

// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared definitions: ALU opcodes, divider FSM states and constants
package div_unit_pkg;

  // ALU operation codes decoded by EX
  localparam logic [4:0] ALUOP_ADD  = 5'd0;
  localparam logic [4:0] ALUOP_SUB  = 5'd1;
  localparam logic [4:0] ALUOP_AND  = 5'd2;
  localparam logic [4:0] ALUOP_OR   = 5'd3;
  localparam logic [4:0] ALUOP_XOR  = 5'd4;
  localparam logic [4:0] ALUOP_SLL  = 5'd5;
  localparam logic [4:0] ALUOP_SRL  = 5'd6;
  localparam logic [4:0] ALUOP_SRA  = 5'd7;
  localparam logic [4:0] ALUOP_SLT  = 5'd8;
  localparam logic [4:0] ALUOP_SLTU = 5'd9;
  // Divide family: EX maps these onto start_i / signed_i / rem_i
  localparam logic [4:0] ALUOP_DIV  = 5'd16;
  localparam logic [4:0] ALUOP_DIVU = 5'd17;
  localparam logic [4:0] ALUOP_REM  = 5'd18;
  localparam logic [4:0] ALUOP_REMU = 5'd19;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  localparam int          DIV_ITERS     = 32;
  localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;

  // Two's-complement negate when neg is set
  function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
    return neg ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative radix-2 restoring divider for DIV/DIVU/REM/REMU
module div_unit
  import div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic        rem_i,
  input  logic [31:0] op1_i,
  input  logic [31:0] op2_i,
  input  logic        annul_i,
  output logic [31:0] result_o,
  output logic        ready_o,
  output logic        stallreq_o
);

  localparam logic [4:0] LAST_ITER = 5'(DIV_ITERS - 1);

  div_state_e  r_state;
  logic [4:0]  r_cnt;
  logic [31:0] r_quo;      // dividend shifts out the top, quotient bits shift in
  logic [31:0] r_rem;      // partial remainder, always below the divisor
  logic [31:0] r_divisor;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_rem_sel;
  logic [31:0] r_result;
  logic        r_ready;

  logic [32:0] w_shift;
  logic [32:0] w_diff;
  logic        w_ge;
  logic [31:0] w_quo_next;
  logic [31:0] w_rem_next;
  logic [31:0] w_q_final;
  logic [31:0] w_r_final;
  logic        w_op1_neg;
  logic        w_op2_neg;

  // One restoring step: when the shifted remainder has bit 32 set it must exceed the divisor
  always_comb begin
    w_shift    = {r_rem, r_quo[31]};
    w_diff     = w_shift - {1'b0, r_divisor};
    w_ge       = w_shift[32] | ~w_diff[32];
    w_quo_next = {r_quo[30:0], w_ge};
    w_rem_next = w_ge ? w_diff[31:0] : w_shift[31:0];
    w_q_final  = cond_neg(w_quo_next, r_neg_q);
    w_r_final  = cond_neg(w_rem_next, r_neg_r);
    w_op1_neg  = signed_i & op1_i[31];
    w_op2_neg  = signed_i & op2_i[31];
  end

  // Control FSM and datapath registers; annul and reset both drop back to IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= DIV_IDLE;
      r_cnt     <= '0;
      r_quo     <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_rem_sel <= 1'b0;
      r_result  <= '0;
      r_ready   <= 1'b0;
    end else if (annul_i) begin
      r_state <= DIV_IDLE;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        DIV_IDLE: begin
          r_ready <= 1'b0;
          if (start_i) begin
            r_quo     <= cond_neg(op1_i, w_op1_neg);
            r_divisor <= cond_neg(op2_i, w_op2_neg);
            r_rem     <= '0;
            r_cnt     <= '0;
            r_neg_q   <= w_op1_neg ^ w_op2_neg;
            r_neg_r   <= w_op1_neg;
            r_rem_sel <= rem_i;
            if (op2_i == 32'd0) begin
              r_result <= rem_i ? op1_i : DIV_BY_ZERO_Q;
              r_ready  <= 1'b1;
              r_state  <= DIV_DONE;
            end else begin
              r_state <= DIV_CALC;
            end
          end
        end
        DIV_CALC: begin
          r_quo <= w_quo_next;
          r_rem <= w_rem_next;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == LAST_ITER) begin
            r_result <= r_rem_sel ? w_r_final : w_q_final;
            r_ready  <= 1'b1;
            r_state  <= DIV_DONE;
          end
        end
        DIV_DONE: begin
          r_ready <= 1'b0;
          r_state <= DIV_IDLE;
        end
        default: begin
          r_ready <= 1'b0;
          r_state <= DIV_IDLE;
        end
      endcase
    end
  end

  assign result_o   = r_result;
  assign ready_o    = r_ready & ~annul_i;
  assign stallreq_o = ~annul_i & (((r_state == DIV_IDLE) & start_i) | (r_state == DIV_CALC));

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking bench for div_unit
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic        signed_i = 1'b0;
  logic        rem_i = 1'b0;
  logic        annul_i = 1'b0;
  logic [31:0] op1_i = '0;
  logic [31:0] op2_i = '0;
  logic [31:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  int n_err = 0;
  int n_chk = 0;

  // behavioural model state
  int          cyc = 0;
  bit          m_valid = 1'b0;
  bit          m_active = 1'b0;
  int          m_done = 0;
  logic [31:0] m_exp = '0;
  logic [31:0] m_result = '0;

  always #5 clk = ~clk;

  div_unit dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .signed_i   (signed_i),
    .rem_i      (rem_i),
    .op1_i      (op1_i),
    .op2_i      (op2_i),
    .annul_i    (annul_i),
    .result_o   (result_o),
    .ready_o    (ready_o),
    .stallreq_o (stallreq_o)
  );

  function automatic logic [31:0] ref_div(input logic s, input logic r,
                                          input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return r ? a : 32'hFFFF_FFFF;
    if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return r ? 32'd0 : 32'h8000_0000;
      return r ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    end
    return r ? (a % b) : (a / b);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Model: an accepted request completes a fixed number of cycles later
  always @(posedge clk) begin
    if (rst) begin
      m_valid  = 1'b1;
      m_active = 1'b0;
      m_result = '0;
    end else if (annul_i) begin
      m_active = 1'b0;
    end else if (m_active) begin
      if (cyc == m_done) m_active = 1'b0;
    end else if (start_i) begin
      m_active = 1'b1;
      m_done   = cyc + ((op2_i == 32'd0) ? 1 : 33);
      m_exp    = ref_div(signed_i, rem_i, op1_i, op2_i);
    end
    cyc = cyc + 1;
  end

  // Compare every cycle mid-period
  always @(negedge clk) begin
    if (m_valid) begin
      if (m_active && cyc == m_done) m_result = m_exp;
      check("ready_o", {31'd0, ready_o}, {31'd0, m_active && cyc == m_done && !annul_i});
      check("stallreq_o", {31'd0, stallreq_o},
            {31'd0, !annul_i && (m_active ? (cyc < m_done) : start_i)});
      check("result_o", result_o, m_result);
    end
  end

  task automatic run_op(input string name, input logic s, input logic r,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input bit toggle);
    int  t0;
    bit  got;
    @(posedge clk); #1;
    signed_i = s; rem_i = r; op1_i = a; op2_i = b; start_i = 1'b1;
    t0  = cyc;
    got = 1'b0;
    for (int n = 0; n < 60 && !got; n++) begin
      @(negedge clk);
      if (ready_o) got = 1'b1;
      else begin
        check({name, " stall"}, {31'd0, stallreq_o}, 32'd1);
        if (toggle && cyc > t0) begin
          op1_i = $urandom; op2_i = $urandom; signed_i = ~signed_i; rem_i = ~rem_i;
        end
      end
    end
    if (!got) begin
      n_chk++; n_err++;
      $display("FAIL %s: timeout, ready_o never seen (required within 60 cycles)", name);
    end else begin
      check({name, " latency"}, 32'(cyc - t0), 32'(lat));
      check({name, " result"}, result_o, exp);
    end
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset result_o", result_o, 32'd0);
    check("reset ready_o", {31'd0, ready_o}, 32'd0);
    check("reset stallreq_o", {31'd0, stallreq_o}, 32'd0);

    run_op("DIVU 100/7",      1'b0, 1'b0, 32'd100,         32'd7,           32'd14,          33, 1'b0);
    run_op("REMU 100/7",      1'b0, 1'b1, 32'd100,         32'd7,           32'd2,           33, 1'b0);
    run_op("DIV -7/2",        1'b1, 1'b0, 32'hFFFF_FFF9,   32'd2,           32'hFFFF_FFFD,   33, 1'b0);
    run_op("REM -7/2",        1'b1, 1'b1, 32'hFFFF_FFF9,   32'd2,           32'hFFFF_FFFF,   33, 1'b0);
    run_op("DIV 7/-2",        1'b1, 1'b0, 32'd7,           32'hFFFF_FFFE,   32'hFFFF_FFFD,   33, 1'b0);
    run_op("REM 7/-2",        1'b1, 1'b1, 32'd7,           32'hFFFF_FFFE,   32'd1,           33, 1'b0);
    run_op("REM -8/-3",       1'b1, 1'b1, 32'hFFFF_FFF8,   32'hFFFF_FFFD,   32'hFFFF_FFFE,   33, 1'b0);
    run_op("DIV 5/0",         1'b1, 1'b0, 32'd5,           32'd0,           32'hFFFF_FFFF,   1,  1'b0);
    run_op("REM 5/0",         1'b1, 1'b1, 32'd5,           32'd0,           32'd5,           1,  1'b0);
    run_op("DIVU max/0",      1'b0, 1'b0, 32'hFFFF_FFFF,   32'd0,           32'hFFFF_FFFF,   1,  1'b0);
    run_op("DIV ovf",         1'b1, 1'b0, 32'h8000_0000,   32'hFFFF_FFFF,   32'h8000_0000,   33, 1'b0);
    run_op("REM ovf",         1'b1, 1'b1, 32'h8000_0000,   32'hFFFF_FFFF,   32'd0,           33, 1'b0);
    run_op("REMU 0x8.../max", 1'b0, 1'b1, 32'h8000_0000,   32'hFFFF_FFFF,   32'h8000_0000,   33, 1'b0);
    run_op("DIVU max/1",      1'b0, 1'b0, 32'hFFFF_FFFF,   32'd1,           32'hFFFF_FFFF,   33, 1'b0);

    // annul part-way through CALC
    @(posedge clk); #1;
    signed_i = 1'b0; rem_i = 1'b0; op1_i = 32'd1000; op2_i = 32'd3; start_i = 1'b1;
    repeat (11) @(posedge clk);
    #1 annul_i = 1'b1; start_i = 1'b0;
    @(negedge clk);
    check("annul stallreq_o", {31'd0, stallreq_o}, 32'd0);
    check("annul ready_o", {31'd0, ready_o}, 32'd0);
    @(posedge clk); #1 annul_i = 1'b0;
    @(negedge clk);
    check("post-annul stallreq_o", {31'd0, stallreq_o}, 32'd0);
    repeat (30) @(posedge clk);
    run_op("DIVU 9/3", 1'b0, 1'b0, 32'd9, 32'd3, 32'd3, 33, 1'b0);

    // reset part-way through CALC
    @(posedge clk); #1;
    signed_i = 1'b0; rem_i = 1'b0; op1_i = 32'h1234_5678; op2_i = 32'h111; start_i = 1'b1;
    repeat (21) @(posedge clk);
    #1 rst = 1'b1; start_i = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mid-reset result_o", result_o, 32'd0);
    check("mid-reset ready_o", {31'd0, ready_o}, 32'd0);
    check("mid-reset stallreq_o", {31'd0, stallreq_o}, 32'd0);
    repeat (20) @(posedge clk);

    // operands wiggled while CALC runs must not disturb the result
    run_op("DIVU toggled", 1'b0, 1'b0, 32'd1000000, 32'd7, 32'd142857, 33, 1'b1);
    run_op("REMU toggled", 1'b0, 1'b1, 32'd1000000, 32'd7, 32'd1,      33, 1'b1);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached (errors=%0d)", n_err);
    $fatal(1, "watchdog");
  end

endmodule
